// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the architectural widths and the reset fetch address.
// Imported by the fetch-stage blocks to supply default parameter values.
package cpu_pkg;

    // Architectural register / address width.
    localparam int XLEN = 32;

    // Size of one instruction in bytes (sequential PC step).
    localparam int INSN_BYTES = 4;

    // First instruction address after reset.
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef logic [XLEN-1:0] addr_t;

endpackage

// File: rtl/pc_block_unit.sv
// Fetch-stage program counter: advances by STEP or loads an aligned branch target.
// Ports: clk, rst_n (async low), addr (target), branch (load target), pc (= pc_q).
module pc_block_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH        = XLEN,
    parameter int               STEP         = INSN_BYTES,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_PC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] addr,
    input  logic             branch,
    output logic [WIDTH-1:0] pc
);

    // Clearing the low log2(STEP) bits keeps every loaded PC STEP-aligned.
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - WIDTH'(1));

    if (STEP < 1 || (STEP & (STEP - 1)) != 0) begin : g_bad_step
        $error("pc_block_unit: STEP must be a power of two");
    end

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] pc_tgt;

    // Next-PC select kept apart from the register so stall/flush
    // terms can be added to this mux later.
    always_comb begin
        pc_seq = pc_q + STEP_W;
        pc_tgt = addr & ALIGN_MASK;
        pc_d   = pc_seq;
        if (branch) begin
            pc_d = pc_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_pc_block_unit.sv
// Scoreboard bench for pc_block_unit: default instance plus a STEP=2 /
// RESET_VECTOR=0x100 instance, each with its own expected-value queue.
module tb_pc_block_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] pc;

    logic        rst2_n = 1'b0;
    logic        branch2 = 1'b0;
    logic [31:0] addr2 = 32'h0;
    logic [31:0] pc2;

    int checks = 0;
    int errors = 0;

    logic [31:0] q1[$];
    string       n1[$];
    logic [31:0] q2[$];
    string       n2[$];

    always #5 clk = ~clk;

    pc_block_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .branch (branch),
        .pc     (pc)
    );

    pc_block_unit #(
        .WIDTH        (32),
        .STEP         (2),
        .RESET_VECTOR (32'h100)
    ) dut2 (
        .clk    (clk),
        .rst_n  (rst2_n),
        .addr   (addr2),
        .branch (branch2),
        .pc     (pc2)
    );

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            assert (!$isunknown(branch))
            else $error("X on branch while out of reset");
        end
    end

    // Monitors: sample 1 time unit after each clock edge or reset
    // assertion and compare against the oldest pending expectation.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (q1.size() != 0) begin
                logic [31:0] e;
                string nm;
                e  = q1.pop_front();
                nm = n1.pop_front();
                checks++;
                if (pc !== e) begin
                    errors++;
                    $display("FAIL %s: pc=%h expected=%h", nm, pc, e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk or negedge rst2_n);
            #1;
            if (q2.size() != 0) begin
                logic [31:0] e;
                string nm;
                e  = q2.pop_front();
                nm = n2.pop_front();
                checks++;
                if (pc2 !== e) begin
                    errors++;
                    $display("FAIL %s: pc2=%h expected=%h", nm, pc2, e);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic b, input logic [31:0] a,
                       input logic [31:0] e, input string nm);
        @(negedge clk);
        rst_n  = r;
        branch = b;
        addr   = a;
        q1.push_back(e);
        n1.push_back(nm);
    endtask

    task automatic cyc2(input logic r, input logic b, input logic [31:0] a,
                        input logic [31:0] e, input string nm);
        @(negedge clk);
        rst2_n  = r;
        branch2 = b;
        addr2   = a;
        q2.push_back(e);
        n2.push_back(nm);
    endtask

    initial begin
        // reset held, pc stays at reset vector
        cyc(1'b0, 1'b0, 32'h0, 32'h0, "rst_hold0");
        cyc(1'b0, 1'b0, 32'h0, 32'h0, "rst_hold1");
        cyc(1'b0, 1'b0, 32'h0, 32'h0, "rst_hold2");
        // release and increment
        cyc(1'b1, 1'b0, 32'h0, 32'h4, "inc_4");
        cyc(1'b1, 1'b0, 32'h0, 32'h8, "inc_8");
        // branch held two edges, then resume
        cyc(1'b1, 1'b1, 32'h1234, 32'h1234, "br_1");
        cyc(1'b1, 1'b1, 32'h1234, 32'h1234, "br_hold");
        cyc(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1238, "br_resume0");
        cyc(1'b1, 1'b0, 32'h0, 32'h123C, "br_resume1");
        // misaligned target
        cyc(1'b1, 1'b1, 32'h1237, 32'h1234, "misalign");
        cyc(1'b1, 1'b0, 32'h0, 32'h1238, "misalign_inc");
        // wrap-around
        cyc(1'b1, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, "wrap_br");
        cyc(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, "wrap_inc0");
        cyc(1'b1, 1'b0, 32'h0, 32'h0000_0000, "wrap_inc1");
        cyc(1'b1, 1'b0, 32'h0, 32'h0000_0004, "wrap_inc2");
        // async reset mid-cycle with branch pending
        cyc(1'b1, 1'b1, 32'h1238, 32'h1238, "pre_async");
        @(posedge clk);
        #3;
        branch = 1'b1;
        addr   = 32'h5678;
        q1.push_back(32'h0);
        n1.push_back("async_rst");
        rst_n = 1'b0;
        cyc(1'b0, 1'b1, 32'h5678, 32'h0, "rst_vs_br0");
        cyc(1'b0, 1'b1, 32'h5678, 32'h0, "rst_vs_br1");
        // first edge after release performs a branch
        cyc(1'b1, 1'b1, 32'h42, 32'h40, "rel_branch");
        cyc(1'b1, 1'b0, 32'h0, 32'h44, "rel_inc");

        // parameter-override instance
        cyc2(1'b0, 1'b0, 32'h0, 32'h100, "p2_rst");
        cyc2(1'b1, 1'b0, 32'h0, 32'h102, "p2_inc0");
        cyc2(1'b1, 1'b0, 32'h0, 32'h104, "p2_inc1");
        cyc2(1'b1, 1'b1, 32'h201, 32'h200, "p2_br");
        cyc2(1'b1, 1'b0, 32'h0, 32'h202, "p2_br_inc");

        @(negedge clk);
        branch  = 1'b0;
        branch2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (q1.size() == 0 && q2.size() == 0) break;
            @(negedge clk);
        end
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0",
                     q1.size() + q2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
